// File: rtl/note_pkg.sv
// Shared types and constants for the organ note back end (note code, octave, divider table).
package note_pkg;

  localparam int unsigned HP_W = 18;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    PLAY = 2'd2
  } state_t;

  localparam logic [2:0] NOTE_REST = 3'd0;
  localparam logic [2:0] NOTE_C    = 3'd1;
  localparam logic [2:0] NOTE_D    = 3'd2;
  localparam logic [2:0] NOTE_E    = 3'd3;
  localparam logic [2:0] NOTE_F    = 3'd4;
  localparam logic [2:0] NOTE_G    = 3'd5;
  localparam logic [2:0] NOTE_A    = 3'd6;
  localparam logic [2:0] NOTE_B    = 3'd7;

  localparam logic [1:0] OCT_REST = 2'b00;
  localparam logic [1:0] OCT_LOW  = 2'b01;
  localparam logic [1:0] OCT_MID  = 2'b10;
  localparam logic [1:0] OCT_HIGH = 2'b11;

  typedef struct packed {
    logic [1:0] tone;
    logic [2:0] value;
  } note_code_t;

  // Mid-octave half-period counts at 50 MHz, C..B.
  localparam logic [HP_W-1:0] MID_HP [7] = '{
    18'd95420, 18'd85034, 18'd75758, 18'd71633, 18'd63776, 18'd56818, 18'd50607
  };

  function automatic logic is_silent(input note_code_t code);
    return (code.value == NOTE_REST) || (code.tone == OCT_REST);
  endfunction

endpackage

// File: rtl/note_div_lut.sv
// Maps a {tone,value} code to its half-period count, scaled down by HALF_SHIFT and clamped to >=1.
module note_div_lut import note_pkg::*; #(
  parameter int unsigned HALF_SHIFT = 0
) (
  input  note_code_t      code,
  output logic [HP_W-1:0] hp_c
);

  logic [HP_W-1:0] base_c;
  logic [HP_W-1:0] oct_c;
  logic [HP_W-1:0] shifted_c;

  always_comb begin
    base_c = MID_HP[0];
    case (code.value)
      NOTE_D:  base_c = MID_HP[1];
      NOTE_E:  base_c = MID_HP[2];
      NOTE_F:  base_c = MID_HP[3];
      NOTE_G:  base_c = MID_HP[4];
      NOTE_A:  base_c = MID_HP[5];
      NOTE_B:  base_c = MID_HP[6];
      default: base_c = MID_HP[0];
    endcase

    oct_c = base_c;
    case (code.tone)
      OCT_LOW:  oct_c = base_c << 1;
      OCT_HIGH: oct_c = base_c >> 1;
      default:  oct_c = base_c;
    endcase

    shifted_c = oct_c >> HALF_SHIFT;
    hp_c      = (shifted_c == '0) ? HP_W'(1) : shifted_c;
  end

endmodule

// File: rtl/note_synth.sv
// Note-code to buzzer square-wave generator with a silent articulation gap between notes.
// NOTE_SYNTH_GAP_EN: when defined, a note change passes through the GAP state for GAP_CYCLES cycles.
module note_synth import note_pkg::*; #(
  parameter int unsigned GAP_CYCLES = 250000,
  parameter int unsigned HALF_SHIFT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] value_in,
  input  logic [1:0] tone_in,
  output logic       buzz,
  output logic       note_active,
  output logic       note_strobe
);

  state_t          state, state_nxt;
  note_code_t      code_q, cur_code, cur_code_nxt;
  logic [HP_W-1:0] half_cnt, half_cnt_nxt;
  logic [HP_W-1:0] hp_c;
  logic            buzz_nxt;
  logic            strobe_nxt;

`ifdef NOTE_SYNTH_GAP_EN
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
  logic [GAP_W-1:0] gap_cnt, gap_cnt_nxt;
`endif

  // Every decision reads code_q, so lookups only ever need the registered code.
  note_div_lut #(.HALF_SHIFT(HALF_SHIFT)) u_lut (
    .code (code_q),
    .hp_c (hp_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) code_q <= '0;
    else     code_q <= '{tone: tone_in, value: value_in};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cur_code    <= '0;
      half_cnt    <= '0;
      buzz        <= 1'b0;
      note_active <= 1'b0;
      note_strobe <= 1'b0;
`ifdef NOTE_SYNTH_GAP_EN
      gap_cnt     <= '0;
`endif
    end else begin
      state       <= state_nxt;
      cur_code    <= cur_code_nxt;
      half_cnt    <= half_cnt_nxt;
      buzz        <= buzz_nxt;
      note_active <= (state_nxt == PLAY);
      note_strobe <= strobe_nxt;
`ifdef NOTE_SYNTH_GAP_EN
      gap_cnt     <= gap_cnt_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt    = state;
    cur_code_nxt = cur_code;
    half_cnt_nxt = half_cnt;
    buzz_nxt     = buzz;
    strobe_nxt   = 1'b0;
`ifdef NOTE_SYNTH_GAP_EN
    gap_cnt_nxt  = gap_cnt;
`endif
    case (state)
      IDLE: begin
        buzz_nxt = 1'b0;
        if (!is_silent(code_q)) begin
          state_nxt    = PLAY;
          cur_code_nxt = code_q;
          half_cnt_nxt = hp_c - HP_W'(1);
          buzz_nxt     = 1'b1;
          strobe_nxt   = 1'b1;
        end
      end
      PLAY: begin
        if (is_silent(code_q)) begin
          state_nxt = IDLE;
          buzz_nxt  = 1'b0;
        end else if (code_q != cur_code) begin
          cur_code_nxt = code_q;
`ifdef NOTE_SYNTH_GAP_EN
          state_nxt    = GAP;
          buzz_nxt     = 1'b0;
          gap_cnt_nxt  = GAP_LOAD;
`else
          // Re-strike in place; back-to-back changes must not stretch the strobe.
          half_cnt_nxt = hp_c - HP_W'(1);
          buzz_nxt     = 1'b1;
          strobe_nxt   = !note_strobe;
`endif
        end else if (half_cnt == '0) begin
          buzz_nxt     = !buzz;
          half_cnt_nxt = hp_c - HP_W'(1);
        end else begin
          half_cnt_nxt = half_cnt - HP_W'(1);
        end
      end
`ifdef NOTE_SYNTH_GAP_EN
      GAP: begin
        buzz_nxt = 1'b0;
        if (is_silent(code_q)) begin
          state_nxt = IDLE;
        end else if (code_q != cur_code) begin
          cur_code_nxt = code_q;
          gap_cnt_nxt  = GAP_LOAD;
        end else if (gap_cnt == '0) begin
          state_nxt    = PLAY;
          half_cnt_nxt = hp_c - HP_W'(1);
          buzz_nxt     = 1'b1;
          strobe_nxt   = 1'b1;
        end else begin
          gap_cnt_nxt = gap_cnt - GAP_W'(1);
        end
      end
`endif
      default: begin
        state_nxt = IDLE;
        buzz_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_note_synth.sv
// Bench for note_synth: cycle model of the note/gap rules plus directed literal checks.
module tb_note_synth;
  import note_pkg::*;

  localparam int unsigned HS = 10;
  localparam int unsigned GC = 8;
  localparam int M_IDLE = 0;
  localparam int M_GAP  = 1;
  localparam int M_PLAY = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] value_in;
  logic [1:0] tone_in;
  logic       buzz, note_active, note_strobe;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  int m_code = 0, m_mode = 0, m_note = 0, m_t = 0, m_gap = 0;
  bit m_strobe = 1'b0;
  int mc;
  bit mst;

  note_synth #(.GAP_CYCLES(GC), .HALF_SHIFT(HS)) dut (
    .clk         (clk),
    .rst         (rst),
    .value_in    (value_in),
    .tone_in     (tone_in),
    .buzz        (buzz),
    .note_active (note_active),
    .note_strobe (note_strobe)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int hp_of(input int tone, input int value);
    int base;
    int hp;
    case (value)
      1: base = 95420;
      2: base = 85034;
      3: base = 75758;
      4: base = 71633;
      5: base = 63776;
      6: base = 56818;
      default: base = 50607;
    endcase
    if (tone == 1)      base = base * 2;
    else if (tone == 3) base = base / 2;
    hp = base >> HS;
    return (hp < 1) ? 1 : hp;
  endfunction

  function automatic bit silent(input int c);
    return ((c & 7) == 0) || ((c >> 3) == 0);
  endfunction

  function automatic int model_buzz();
    if (m_mode != M_PLAY) return 0;
    return (((m_t / hp_of(m_note >> 3, m_note & 7)) % 2) == 0) ? 1 : 0;
  endfunction

  // Model: note timeline as elapsed-cycles-since-strike; the level is the parity of elapsed/HP.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_code = 0; m_mode = M_IDLE; m_note = 0; m_t = 0; m_gap = 0; m_strobe = 1'b0;
    end else begin
      mc  = m_code;
      mst = 1'b0;
      if (m_mode == M_IDLE) begin
        if (!silent(mc)) begin m_mode = M_PLAY; m_note = mc; m_t = 0; mst = 1'b1; end
      end else if (m_mode == M_PLAY) begin
        if (silent(mc)) m_mode = M_IDLE;
        else if (mc != m_note) begin
`ifdef NOTE_SYNTH_GAP_EN
          m_mode = M_GAP; m_note = mc; m_gap = GC;
`else
          m_note = mc; m_t = 0; mst = !m_strobe;
`endif
        end else m_t++;
      end else begin
        if (silent(mc)) m_mode = M_IDLE;
        else if (mc != m_note) begin m_note = mc; m_gap = GC; end
        else begin
          m_gap--;
          if (m_gap == 0) begin m_mode = M_PLAY; m_t = 0; mst = 1'b1; end
        end
      end
      m_strobe = mst;
      m_code   = int'({tone_in, value_in});
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_buzz", int'(buzz), model_buzz());
      check("model_active", int'(note_active), (m_mode == M_PLAY) ? 1 : 0);
      check("model_strobe", int'(note_strobe), int'(m_strobe));
    end
  end

  task automatic set_code(input int tone, input int value);
    tone_in  = 2'(tone);
    value_in = 3'(value);
  endtask

  task automatic go_idle();
    set_code(0, 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_strobe(input string name);
    int n = 0;
    while (note_strobe !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    check(name, int'(note_strobe), 1);
  endtask

  task automatic run_len(input logic lvl, input string name, input int exp);
    int n = 0;
    while (buzz === lvl && n < 1000) begin n++; @(negedge clk); end
    check(name, n, exp);
  endtask

  initial begin
    int c;
    int s;
    rst = 1'b1;
    set_code(0, 0);
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_buzz", int'(buzz), 0);
    check("rst_active", int'(note_active), 0);
    check("rst_strobe", int'(note_strobe), 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_state", int'(dut.state), int'(IDLE));

    check("hp_mid_a", hp_of(2, 6), 55);
    check("hp_low_a", hp_of(1, 6), 110);
    check("hp_high_a", hp_of(3, 6), 27);
    check("hp_mid_g", hp_of(2, 5), 62);
    check("hp_low_c", hp_of(1, 1), 186);

    // Mid A from IDLE: strobe two edges after the input change.
    set_code(2, 6);
    @(negedge clk);
    check("a_strobe_n1", int'(note_strobe), 0);
    @(negedge clk);
    check("a_strobe_n2", int'(note_strobe), 1);
    check("a_active", int'(note_active), 1);
    run_len(1'b1, "a_high", 55);
    run_len(1'b0, "a_low", 55);
    run_len(1'b1, "a_high2", 55);

    // Octaves: low A then high A.
    go_idle();
    set_code(1, 6);
    wait_strobe("lo_strobe");
    run_len(1'b1, "lo_high", 110);
    set_code(3, 6);
`ifdef NOTE_SYNTH_GAP_EN
    c = 0;
    while (note_active && c < 10) begin @(negedge clk); c++; end
    c = 0;
    while (!note_active && c < 50) begin c++; @(negedge clk); end
    check("oct_gap", c, 8);
    check("hi_strobe", int'(note_strobe), 1);
`else
    wait_strobe("hi_strobe");
`endif
    run_len(1'b1, "hi_high", 27);

    // Rest after C.
    go_idle();
    set_code(2, 1);
    wait_strobe("c_strobe");
    run_len(1'b1, "c_high", 93);
    repeat (10) @(negedge clk);
    set_code(2, 0);
    @(negedge clk);
    check("rest_active_n1", int'(note_active), 1);
    @(negedge clk);
    check("rest_active", int'(note_active), 0);
    check("rest_buzz", int'(buzz), 0);
    check("rest_strobe", int'(note_strobe), 0);

    go_idle();
    set_code(2, 3);
    wait_strobe("e_strobe");
    repeat (5) @(negedge clk);
    set_code(2, 5);
`ifdef NOTE_SYNTH_GAP_EN
    // Change to A on gap cycle 4 restarts the gap.
    c = 0;
    while (note_active && c < 10) begin @(negedge clk); c++; end
    c = 0;
    s = 0;
    while (!note_active && c < 50) begin
      c++;
      if (note_strobe) s++;
      if (c == 4) set_code(2, 6);
      @(negedge clk);
    end
    check("gap_restart_len", c, 13);
    if (note_strobe) s++;
    repeat (3) begin @(negedge clk); if (note_strobe) s++; end
    check("gap_restart_strobes", s, 1);
    run_len(1'b1, "a_after_gap_high", 52);
`else
    // Re-strike E->G inside PLAY without silence.
    @(negedge clk);
    check("restrike_n1_buzz", int'(buzz), 1);
    check("restrike_n1_strobe", int'(note_strobe), 0);
    @(negedge clk);
    check("restrike_strobe", int'(note_strobe), 1);
    check("restrike_buzz", int'(buzz), 1);
    check("restrike_active", int'(note_active), 1);
    run_len(1'b1, "g_high", 62);
`endif

    // Asynchronous reset in the middle of a high level.
    go_idle();
    set_code(2, 6);
    wait_strobe("rst_pre_strobe");
    repeat (3) @(negedge clk);
    check("rst_pre_buzz", int'(buzz), 1);
    #2;
    rst = 1'b1;
    set_code(0, 0);
    #1;
    check("rst_async_buzz", int'(buzz), 0);
    check("rst_async_active", int'(note_active), 0);
    check("rst_async_strobe", int'(note_strobe), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_release_state", int'(dut.state), int'(IDLE));
    check("rst_release_active", int'(note_active), 0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
